// File: rtl/sha_pkg.sv
// Shared SHA-2 round-constant tables, sequencer state encoding and
// MODE-derived width/round-count helpers.
package sha_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FIN    = 2'd2
  } seq_state_t;

  function automatic int sha_w(input int mode);
    return (mode == 1) ? 64 : 32;
  endfunction

  function automatic int sha_rounds(input int mode);
    return (mode == 1) ? 80 : 64;
  endfunction

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

endpackage

// File: rtl/k_rom.sv
// Combinational round-constant lookup; indices past the last round read as zero.
module k_rom
  import sha_pkg::*;
#(
  parameter int MODE = 0,
  localparam int W = sha_w(MODE)
) (
  input  logic [6:0]   i_idx,
  output logic [W-1:0] o_k
);

  generate
    if (MODE == 1) begin : g_k512
      always_comb begin
        o_k = '0;
        if (i_idx < 7'd80) o_k = K512[i_idx];
      end
    end else begin : g_k256
      always_comb begin
        o_k = '0;
        if (i_idx < 7'd64) o_k = K256[i_idx[5:0]];
      end
    end
  endgenerate

endmodule

// File: rtl/k_sequencer.sv
// Streams SHA-2 round constants 0..ROUNDS-1 over valid/ready with a 1-cycle start
// latency, plus an independent registered random-access lookup port.
module k_sequencer
  import sha_pkg::*;
#(
  parameter int MODE = 0,
  localparam int W      = sha_w(MODE),
  localparam int ROUNDS = sha_rounds(MODE)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         k_ready,
  output logic         k_valid,
  output logic [W-1:0] k_data,
  output logic [6:0]   k_round,
  output logic         k_last,
  output logic         busy,
  output logic         done,
  input  logic [6:0]   rd_sel,
  output logic [W-1:0] rd_data
);

  generate
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("k_sequencer: MODE must be 0 (SHA-256) or 1 (SHA-512)");
    end
  endgenerate

  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  seq_state_t     r_state;
  logic [6:0]     r_round;
  logic           r_valid;
  logic           r_last;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_data;
  logic [W-1:0]   r_rd_data;

  logic [6:0]     w_next_idx;
  logic [W-1:0]   w_next_k;
  logic [W-1:0]   w_rd_k;
  logic           w_xfer;

  // Prefetch index depends only on registered state, so no input reaches an output combinationally.
  assign w_next_idx = (r_state == S_STREAM) ? r_round + 7'd1 : 7'd0;
  assign w_xfer     = r_valid & k_ready;

  k_rom #(.MODE(MODE)) u_rom_stream (
    .i_idx (w_next_idx),
    .o_k   (w_next_k)
  );

  k_rom #(.MODE(MODE)) u_rom_lookup (
    .i_idx (rd_sel),
    .o_k   (w_rd_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_STREAM;
            r_round <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_data  <= w_next_k;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_FIN;
              r_round <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_round <= r_round + 7'd1;
              r_data  <= w_next_k;
              r_last  <= (r_round + 7'd1 == LAST_RND);
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= w_rd_k;
  end

  assign k_valid = r_valid;
  assign k_data  = r_data;
  assign k_round = r_round;
  assign k_last  = r_last;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_k_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_k_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, k_ready;
  logic [6:0]  rd_sel;
  logic        k_valid, k_last, busy, done;
  logic [31:0] k_data, rd_data;
  logic [6:0]  k_round;

  logic        start1, abort1, k_ready1;
  logic [6:0]  rd_sel1;
  logic        k_valid1, k_last1, busy1, done1;
  logic [63:0] k_data1, rd_data1;
  logic [6:0]  k_round1;

  k_sequencer #(.MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_ready(k_ready),
    .k_valid(k_valid), .k_data(k_data), .k_round(k_round), .k_last(k_last),
    .busy(busy), .done(done), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  k_sequencer #(.MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .k_ready(k_ready1),
    .k_valid(k_valid1), .k_data(k_data1), .k_round(k_round1), .k_last(k_last1),
    .busy(busy1), .done(done1), .rd_sel(rd_sel1), .rd_data(rd_data1)
  );

  // FIPS 180-4 SHA-512 constants; SHA-256 constants are their upper 32 bits.
  localparam logic [63:0] K512_TB [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef struct packed {
    logic [63:0] d;
    logic [6:0]  r;
    logic        last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_done1 = 0;

  // Reference model of the MODE 0 stream: beats still owed, and the done cycle.
  int          m_left;
  bit          m_fin;
  logic [63:0] m_rd;

  function automatic logic [63:0] ref_k(input int mode, input int idx);
    logic [63:0] v;
    v = '0;
    if (mode == 0 && idx < 64) v = {32'h0, K512_TB[idx][63:32]};
    if (mode == 1 && idx < 80) v = K512_TB[idx];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_stream(input int mode);
    int    rounds;
    beat_t b;
    rounds = (mode == 1) ? 80 : 64;
    for (int r = 0; r < rounds; r++) begin
      b.d    = ref_k(mode, r);
      b.r    = 7'(r);
      b.last = (r == rounds - 1);
      if (mode == 1) q1.push_back(b);
      else           q0.push_back(b);
    end
  endtask

  // Advance the model across the posedge just taken, using the inputs held over it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_left = 0;
      m_fin  = 1'b0;
      m_rd   = '0;
    end else begin
      m_rd = ref_k(0, int'(rd_sel));
      if (abort) begin
        m_left = 0;
        m_fin  = 1'b0;
      end else if (m_fin) begin
        m_fin = 1'b0;
      end else if (m_left == 0) begin
        if (start) m_left = 64;
      end else if (k_ready) begin
        m_left--;
        if (m_left == 0) m_fin = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit s, input bit a, input bit r, input logic [6:0] sel);
    start   = s;
    abort   = a;
    k_ready = r;
    rd_sel  = sel;
    if (rst_n && s && !a && m_left == 0 && !m_fin) push_stream(0);
  endtask

  task automatic step(input bit s, input bit a, input bit r, input logic [6:0] sel);
    tick();
    drive(s, a, r, sel);
  endtask

  task automatic run_to_round(input int rnd);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_left == 64 - rnd) break;
      drive(1'b0, 1'b0, 1'b1, 7'($urandom_range(0, 127)));
    end
    chk("reach_round", 64'(64 - m_left), 64'(rnd));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("k_valid", 64'(k_valid), 64'(m_left > 0));
      chk("busy", 64'(busy), 64'((m_left > 0) || m_fin));
      chk("done", 64'(done), 64'(m_fin));
      chk("rd_data", 64'(rd_data), m_rd);
      if (k_valid) begin
        if (q0.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: round %0d with no beat owed", k_round);
        end else begin
          chk("k_data", 64'(k_data), q0[0].d);
          chk("k_round", 64'(k_round), 64'(q0[0].r));
          chk("k_last", 64'(k_last), 64'(q0[0].last));
          if (!abort && k_ready) void'(q0.pop_front());
        end
      end
      if (abort) q0.delete();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done1) n_done1++;
      if (k_valid1) begin
        if (q1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL m1_beat_unexpected: round %0d with no beat owed", k_round1);
        end else begin
          chk("m1_k_data", k_data1, q1[0].d);
          chk("m1_k_round", 64'(k_round1), 64'(q1[0].r));
          chk("m1_k_last", 64'(k_last1), 64'(q1[0].last));
          void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; k_ready = 1'b0; rd_sel = 7'd0;
    start1 = 1'b0; abort1 = 1'b0; k_ready1 = 1'b1; rd_sel1 = 7'd79;
    m_left = 0; m_fin = 1'b0; m_rd = '0;
    #2;
    chk("rst_k_valid", 64'(k_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_m1_k_valid", 64'(k_valid1), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full back-to-back streams in both modes.
    step(1'b1, 1'b0, 1'b1, 7'd0);
    start1 = 1'b1;
    push_stream(1);
    step(1'b0, 1'b0, 1'b1, 7'd5);
    start1 = 1'b0;
    for (int i = 0; i < 90; i++) step(1'b0, 1'b0, 1'b1, 7'($urandom_range(0, 127)));

    // Lookup boundaries.
    step(1'b0, 1'b0, 1'b1, 7'd0);
    step(1'b0, 1'b0, 1'b1, 7'd63);
    step(1'b0, 1'b0, 1'b1, 7'd64);
    step(1'b0, 1'b0, 1'b1, 7'h7F);
    step(1'b0, 1'b0, 1'b1, 7'd79);

    // Consumer stall at round 10.
    step(1'b1, 1'b0, 1'b1, 7'd1);
    run_to_round(10);
    drive(1'b0, 1'b0, 1'b0, 7'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 7'd3);
    tick();
    chk("stall_k_round", 64'(k_round), 64'd10);
    chk("stall_k_data", 64'(k_data), 64'h243185be);
    drive(1'b0, 1'b0, 1'b1, 7'd4);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'b1, 7'($urandom_range(0, 127)));

    // Abort together with start at round 20, then a clean restart.
    step(1'b1, 1'b0, 1'b1, 7'd6);
    run_to_round(20);
    drive(1'b1, 1'b1, 1'b1, 7'd7);
    tick();
    chk("abort_k_valid", 64'(k_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 7'd8);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 7'd9);
    step(1'b1, 1'b0, 1'b1, 7'd10);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'b1, 7'($urandom_range(0, 127)));

    // Reset mid-stream at round 30.
    step(1'b1, 1'b0, 1'b1, 7'd11);
    run_to_round(30);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    chk("midrst_k_valid", 64'(k_valid), 64'd0);
    chk("midrst_k_data", 64'(k_data), 64'd0);
    chk("midrst_k_round", 64'(k_round), 64'd0);
    chk("midrst_k_last", 64'(k_last), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_rd_data", 64'(rd_data), 64'd0);
    m_left = 0; m_fin = 1'b0; m_rd = '0;
    q0.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 7'($urandom_range(0, 127)));

    // Randomised traffic.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 9) < 7, 7'($urandom_range(0, 127)));
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 7'($urandom_range(0, 127)));
    tick();
    chk("m0_beats_outstanding", 64'(q0.size()), 64'd0);

    // MODE 1 lookups and stream completion.
    chk("m1_rd_79", rd_data1, 64'h6c44198c4a475817);
    rd_sel1 = 7'd80;
    @(posedge clk);
    #1;
    chk("m1_rd_80", rd_data1, 64'd0);
    rd_sel1 = 7'd0;
    @(posedge clk);
    #1;
    chk("m1_rd_0", rd_data1, 64'h428a2f98d728ae22);
    chk("m1_beats_outstanding", 64'(q1.size()), 64'd0);
    chk("m1_done_pulses", 64'(n_done1), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
